// File: rtl/palette_ctrl_if.sv
// ----------------------------------------------------------------------------
// palette_ctrl_if
// Pixel-lookup and CPU-write bus of the palette controller.
//   pix_valid / pix_idx           : lookup request from the pixel pipeline
//   pix_color_valid / pix_color   : lookup result, one cycle later
//   wr_req / wr_addr / wr_data    : CPU write request, held until wr_ack
//   wr_ack                        : one-cycle write-completion pulse
// master = requester side (pixel pipeline + CPU writer), slave = controller.
// ----------------------------------------------------------------------------
interface palette_ctrl_if;
    logic       pix_valid;
    logic [4:0] pix_idx;
    logic       pix_color_valid;
    logic [5:0] pix_color;
    logic       wr_req;
    logic [4:0] wr_addr;
    logic [5:0] wr_data;
    logic       wr_ack;

    modport master (
        output pix_valid, pix_idx, wr_req, wr_addr, wr_data,
        input  pix_color_valid, pix_color, wr_ack
    );

    modport slave (
        input  pix_valid, pix_idx, wr_req, wr_addr, wr_data,
        output pix_color_valid, pix_color, wr_ack
    );
endinterface

// File: rtl/palette_ctrl.sv
// ----------------------------------------------------------------------------
// palette_ctrl
// Owns the 32 x 6-bit NES palette. After reset or reload it copies the
// combinational palette ROM into its register file (INIT), then serves
// one-cycle lookups and single-port CPU writes (RUN). NES mirroring is applied
// on every write; reads with colour bits 00 return the universal backdrop.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   rom_addr_o   : ROM address (copy counter in INIT, 0 in RUN)
//   rom_dout_i   : ROM data, bits [5:0] are stored
//   reload_i     : one-cycle pulse restarting the ROM copy
//   init_done_o  : high while in RUN
//   bus          : lookup/write bus (palette_ctrl_if.slave)
// ----------------------------------------------------------------------------
module palette_ctrl (
    input  logic                 clk,
    input  logic                 rst,
    output logic [4:0]           rom_addr_o,
    input  logic [7:0]           rom_dout_i,
    input  logic                 reload_i,
    output logic                 init_done_o,
    palette_ctrl_if.slave        bus
);
    typedef enum logic {S_INIT, S_RUN} state_e;

    state_e     state_q, state_d;
    logic [4:0] cnt_q, cnt_d;
    logic       wr_ack_q, wr_ack_d;
    logic       pix_color_valid_q, pix_color_valid_d;
    logic [5:0] pix_color_q, pix_color_d;
    logic [5:0] mem_q [32];

    logic       wr_accept;
    logic [4:0] rd_addr;
    logic       unused_rom_hi;

    // Sprite colour 0 of each sprite palette aliases the matching background entry.
    function automatic logic [4:0] mirror(input logic [4:0] a);
        return (a[4] && (a[1:0] == 2'b00)) ? {1'b0, a[3:0]} : a;
    endfunction

    assign unused_rom_hi = ^rom_dout_i[7:6];

    // Colour 0 of any palette shows the universal backdrop in entry 0.
    assign rd_addr = (bus.pix_idx[1:0] == 2'b00) ? 5'd0 : bus.pix_idx;

    // The pixel reader owns the port; !wr_ack_q enforces two-cycle spacing.
    assign wr_accept = (state_q == S_RUN) && bus.wr_req && !bus.pix_valid && !wr_ack_q;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        state_d           = state_q;
        cnt_d             = cnt_q;
        wr_ack_d          = wr_accept;
        pix_color_valid_d = bus.pix_valid;
        pix_color_d       = pix_color_q;
        rom_addr_o        = 5'd0;

        case (state_q)
            S_INIT: begin
                rom_addr_o = cnt_q;
                cnt_d      = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = S_RUN;
                end
                if (bus.pix_valid) begin
                    pix_color_d = 6'h0F;
                end
            end
            S_RUN: begin
                if (bus.pix_valid) begin
                    pix_color_d = mem_q[rd_addr];
                end
            end
            default: begin
                state_d = S_INIT;
            end
        endcase

        // Reload wins over the INIT->RUN step and restarts the copy.
        if (reload_i) begin
            state_d = S_INIT;
            cnt_d   = 5'd0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q           <= S_INIT;
            cnt_q             <= 5'd0;
            wr_ack_q          <= 1'b0;
            pix_color_valid_q <= 1'b0;
            pix_color_q       <= 6'h00;
        end else begin
            state_q           <= state_d;
            cnt_q             <= cnt_d;
            wr_ack_q          <= wr_ack_d;
            pix_color_valid_q <= pix_color_valid_d;
            pix_color_q       <= pix_color_d;
        end
    end

    // NOTE: the palette store has no reset; the ROM copy after reset rewrites every entry.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == S_INIT) begin
                mem_q[mirror(cnt_q)] <= rom_dout_i[5:0];
            end else if (wr_accept) begin
                mem_q[mirror(bus.wr_addr)] <= bus.wr_data;
            end
        end
    end

    assign init_done_o         = (state_q == S_RUN);
    assign bus.wr_ack          = wr_ack_q;
    assign bus.pix_color_valid = pix_color_valid_q;
    assign bus.pix_color       = pix_color_q;
endmodule

// File: tb/tb_palette_ctrl.sv
// ----------------------------------------------------------------------------
// tb_palette_ctrl
// Self-checking bench for palette_ctrl: ROM copy timing, table of lookups,
// write handshake, pixel priority, mirroring, reload and mid-copy reset, then
// randomized traffic against a palette model.
// ----------------------------------------------------------------------------
module tb_palette_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rom_addr;
    logic [7:0] rom_dout;
    logic       reload;
    logic       init_done;
    logic [5:0] rom [32];

    palette_ctrl_if bus ();

    palette_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .rom_addr_o  (rom_addr),
        .rom_dout_i  (rom_dout),
        .reload_i    (reload),
        .init_done_o (init_done),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    // Combinational ROM; upper bits set so that storing them would show up.
    assign rom_dout = {2'b10, rom[rom_addr]};

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [4:0] idx;
        logic [5:0] exp;
        string      name;
    } vec_t;
    vec_t vecs [12];

    // Palette model: 32 colours as seen by software.
    logic [5:0] pal [32];

    function automatic void pal_write(input int a, input logic [5:0] d);
        if (a >= 16 && a % 4 == 0) pal[a - 16] = d;
        else                       pal[a]      = d;
    endfunction

    function automatic logic [5:0] pal_read(input int idx);
        return (idx % 4 == 0) ? pal[0] : pal[idx];
    endfunction

    function automatic void pal_from_rom();
        for (int i = 0; i < 32; i++) pal_write(i, rom[i]);
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic lookup(input logic [4:0] idx, input logic [5:0] exp, input string name);
        bus.pix_valid = 1'b1;
        bus.pix_idx   = idx;
        step();
        check({name, "_vld"}, {7'd0, bus.pix_color_valid}, 8'd1);
        check(name, {2'b00, bus.pix_color}, {2'b00, exp});
        bus.pix_valid = 1'b0;
    endtask

    // Called in the first cycle with rst low / after the reload edge.
    task automatic run_init(input string tag);
        for (int k = 0; k < 32; k++) begin
            check({tag, "_rom_addr"}, {3'd0, rom_addr}, 8'(k));
            check({tag, "_busy"}, {7'd0, init_done}, 8'd0);
            step();
        end
        check({tag, "_init_done"}, {7'd0, init_done}, 8'd1);
        check({tag, "_run_rom_addr"}, {3'd0, rom_addr}, 8'd0);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_rom_addr"}, {3'd0, rom_addr}, 8'd0);
        check({tag, "_init_done"}, {7'd0, init_done}, 8'd0);
        check({tag, "_wr_ack"}, {7'd0, bus.wr_ack}, 8'd0);
        check({tag, "_pcv"}, {7'd0, bus.pix_color_valid}, 8'd0);
        check({tag, "_pix_color"}, {2'b00, bus.pix_color}, 8'h00);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         n;
        logic [5:0] exp_color;
        logic       exp_ack;
        logic       color_known;
        logic       accept;

        // ROM contents: filler plus the game palette values exercised below.
        for (int i = 0; i < 32; i++) rom[i] = 6'((i * 5 + 9) % 64);
        rom[5'h00] = 6'h3F;  // overwritten in entry 0 by rom[0x10]
        rom[5'h01] = 6'h20;
        rom[5'h05] = 6'h11;
        rom[5'h0A] = 6'h2C;
        rom[5'h0D] = 6'h19;
        rom[5'h10] = 6'h0F;
        rom[5'h11] = 6'h27;
        rom[5'h1D] = 6'h33;
        rom[5'h1F] = 6'h17;

        vecs[0]  = '{5'h01, 6'h20, "lk01"};
        vecs[1]  = '{5'h11, 6'h27, "lk11"};
        vecs[2]  = '{5'h1F, 6'h17, "lk1F"};
        vecs[3]  = '{5'h10, 6'h0F, "lk10"};
        vecs[4]  = '{5'h05, 6'h11, "lk05"};
        vecs[5]  = '{5'h0D, 6'h19, "lk0D"};
        vecs[6]  = '{5'h00, 6'h0F, "lk00"};
        vecs[7]  = '{5'h0C, 6'h0F, "lk0C"};
        vecs[8]  = '{5'h14, 6'h0F, "lk14"};
        vecs[9]  = '{5'h1C, 6'h0F, "lk1C"};
        vecs[10] = '{5'h1D, 6'h33, "lk1D"};
        vecs[11] = '{5'h0A, 6'h2C, "lk0A"};

        rst = 1'b1;  reload = 1'b0;
        bus.pix_valid = 1'b0;  bus.pix_idx = 5'd0;
        bus.wr_req = 1'b0;  bus.wr_addr = 5'd0;  bus.wr_data = 6'd0;
        step(); step(); step();
        check_reset("rst");
        rst = 1'b0;
        run_init("init");

        // Table of lookups after the first copy.
        for (int i = 0; i < 12; i++) lookup(vecs[i].idx, vecs[i].exp, vecs[i].name);

        // Back-to-back lookups, one per cycle.
        bus.pix_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.pix_idx = vecs[i].idx;
            step();
            check({"b2b_", vecs[i].name}, {2'b00, bus.pix_color}, {2'b00, vecs[i].exp});
        end
        bus.pix_valid = 1'b0;
        step();
        check("hold_pcv", {7'd0, bus.pix_color_valid}, 8'd0);
        check("hold_color", {2'b00, bus.pix_color}, {2'b00, vecs[3].exp});

        // Simple write 0x05 <= 0x2A.
        bus.wr_req = 1'b1;  bus.wr_addr = 5'h05;  bus.wr_data = 6'h2A;
        step();
        check("wr05_ack", {7'd0, bus.wr_ack}, 8'd1);
        bus.wr_req = 1'b0;
        step();
        check("wr05_ack_pulse", {7'd0, bus.wr_ack}, 8'd0);
        lookup(5'h05, 6'h2A, "rd05");

        // Pixel traffic holds off the writer for 10 cycles.
        bus.wr_req = 1'b1;  bus.wr_addr = 5'h0A;  bus.wr_data = 6'h01;
        bus.pix_valid = 1'b1;  bus.pix_idx = 5'h01;
        for (int i = 0; i < 10; i++) begin
            step();
            check("starve_no_ack", {7'd0, bus.wr_ack}, 8'd0);
            check("starve_color", {2'b00, bus.pix_color}, 8'h20);
        end
        bus.pix_valid = 1'b0;
        step();
        check("starve_ack", {7'd0, bus.wr_ack}, 8'd1);
        bus.wr_req = 1'b0;
        lookup(5'h0A, 6'h01, "rd0A");
        check("starve_ack_drop", {7'd0, bus.wr_ack}, 8'd0);

        // Mirrored write to 0x10 lands in the backdrop.
        bus.wr_req = 1'b1;  bus.wr_addr = 5'h10;  bus.wr_data = 6'h30;
        step();
        check("wr10_ack", {7'd0, bus.wr_ack}, 8'd1);
        bus.wr_req = 1'b0;
        step();
        lookup(5'h00, 6'h30, "mir00");
        lookup(5'h10, 6'h30, "mir10");
        lookup(5'h14, 6'h30, "mir14");
        lookup(5'h0C, 6'h30, "mir0C");
        lookup(5'h0D, 6'h19, "mir0D");

        // Reload: black during the copy, write held off until RUN.
        reload = 1'b1;
        step();
        reload = 1'b0;
        check("reload_init_done", {7'd0, init_done}, 8'd0);
        bus.wr_req = 1'b1;  bus.wr_addr = 5'h1D;  bus.wr_data = 6'h05;
        lookup(5'h01, 6'h0F, "copy_black01");
        lookup(5'h05, 6'h0F, "copy_black05");
        lookup(5'h11, 6'h0F, "copy_black11");
        n = 3;
        while (!init_done && n < 40) begin
            check("copy_no_ack", {7'd0, bus.wr_ack}, 8'd0);
            step();
            n++;
        end
        check("reload_len", 8'(n), 8'd32);
        step();
        check("held_wr_ack", {7'd0, bus.wr_ack}, 8'd1);
        bus.wr_req = 1'b0;
        lookup(5'h05, 6'h11, "reload_rd05");
        lookup(5'h00, 6'h0F, "reload_rd00");
        lookup(5'h0A, 6'h2C, "reload_rd0A");
        lookup(5'h1D, 6'h05, "held_rd1D");

        // Reset at copy count 17.
        reload = 1'b1;
        step();
        reload = 1'b0;
        for (int i = 0; i < 17; i++) step();
        check("mid_copy_addr", {3'd0, rom_addr}, 8'd17);
        rst = 1'b1;
        step();
        check_reset("rst17");
        rst = 1'b0;
        run_init("reinit");

        // Randomized traffic in RUN against the palette model.
        pal_from_rom();
        exp_ack     = 1'b0;
        exp_color   = 6'h00;
        color_known = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (bus.wr_req && exp_ack) bus.wr_req = 1'b0;
            else if (!bus.wr_req && $urandom_range(0, 2) == 0) begin
                bus.wr_req  = 1'b1;
                bus.wr_addr = 5'($urandom_range(0, 31));
                bus.wr_data = 6'($urandom_range(0, 63));
            end
            bus.pix_valid = (c == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            bus.pix_idx   = 5'($urandom_range(0, 31));

            accept = bus.wr_req && !bus.pix_valid && !exp_ack;
            if (bus.pix_valid) begin
                exp_color   = pal_read(int'(bus.pix_idx));
                color_known = 1'b1;
            end
            if (accept) pal_write(int'(bus.wr_addr), bus.wr_data);
            exp_ack = accept;
            step();

            check("rnd_pcv", {7'd0, bus.pix_color_valid}, {7'd0, bus.pix_valid});
            check("rnd_ack", {7'd0, bus.wr_ack}, {7'd0, exp_ack});
            if (color_known) check("rnd_color", {2'b00, bus.pix_color}, {2'b00, exp_color});
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/palette_ctrl.md
# palette_ctrl

Palette controller that owns the 32-entry, 6-bit NES palette store used by the picture pipeline. After reset, or on a reload command, it copies the combinational palette ROM into its own register file. It then serves one-cycle-latency colour lookups to the pixel pipeline and arbitrates single-port write access between the pixel reader and a CPU-side writer. It applies NES palette mirroring on every write and on every read.

## Interface
- No parameters. Depth is fixed at 32 entries and colour width at 6 bits.
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- rom_addr  out  5  address to the palette ROM, which is combinational and answers in the same cycle
- rom_dout  in  8  ROM data; only bits [5:0] are stored
- reload  in  1  single-cycle pulse; restarts the ROM copy
- init_done  out  1  high while in RUN
- pix_valid  in  1  pixel lookup request
- pix_idx  in  5  palette index (bit 4 = sprite, [3:2] = palette, [1:0] = colour)
- pix_color_valid  out  1  registered copy of pix_valid
- pix_color  out  6  NES system colour
- wr_req  in  1  write request; the requester holds it until wr_ack
- wr_addr  in  5  write address
- wr_data  in  6  write data
- wr_ack  out  1  one-cycle pulse marking write completion

## Operation
- States: INIT and RUN.
- Reset values: state INIT, copy counter 0, rom_addr 0, init_done 0, wr_ack 0, pix_color_valid 0, pix_color 6'h00.
- INIT:
  - Each cycle, rom_addr = counter and entry mirror(counter) <= rom_dout[5:0].
  - The counter increments and wraps from 31 to 0.
  - After the write at counter 31, the state goes to RUN.
- RUN: rom_addr holds 0.
- Write mirroring: mirror(a) = {1'b0, a[3:0]} when a[4]==1 and a[1:0]==0; otherwise mirror(a) = a. Addresses 0x10/0x14/0x18/0x1C therefore alias 0x00/0x04/0x08/0x0C. The copy applies mirroring too, so ROM entry 0x1C overwrites entry 0x0C.
- Read mapping: if pix_idx[1:0]==0, the lookup reads entry 0 (universal backdrop). Otherwise it reads entry pix_idx.
- Lookups:
  - pix_color_valid <= pix_valid every cycle, in every state.
  - In RUN, pix_color <= entry(read map).
  - In INIT, pix_color <= 6'h0F (black).
  - When pix_valid is 0, pix_color holds its previous value.
- Write arbitration (single port; the pixel reader has priority):
  - A write is accepted when state==RUN && wr_req && !pix_valid && !wr_ack.
  - On accept, entry mirror(wr_addr) <= wr_data at that edge, and wr_ack <= 1 for exactly one cycle.
  - There is no starvation guard. The writer waits for pixel blanking.
  - wr_req during INIT is held off, and is accepted in the first eligible RUN cycle.
- reload:
  - In RUN, reload moves the state to INIT with counter 0, and init_done drops.
  - A reload pulse during INIT restarts the counter at 0.
  - A write accepted in the same cycle as reload still completes and acks; the new copy then overwrites it.
- rst mid-INIT or mid-RUN: immediate return to the reset values. Palette contents are not cleared but are rewritten by the copy.

## Timing
- Copy length: 32 cycles. In the first cycle with rst low, rom_addr = 0. init_done rises on the edge after the counter-31 write, i.e. visible in cycle 32 after reset release.
- Lookup latency: 1 cycle. pix_idx sampled at edge N gives pix_color and pix_color_valid valid after edge N.
- Write visibility: a write accepted at edge N is seen by lookups sampled at edge N+1 or later. wr_ack is high in the cycle after edge N.
- Minimum write spacing: 2 cycles per write, enforced by the !wr_ack term.
- Back-to-back lookups run at 1 per cycle, with no bubbles.

## Test plan
- Reset, then release with a ROM model loaded with the 32-entry game palette (entries 0x01=0x20, 0x10=0x0F, 0x11=0x27, 0x1F=0x17) -> init_done=1 in cycle 32. Lookups of idx 0x01, 0x11, 0x1F, 0x10 return 0x20, 0x27, 0x17, 0x0F one cycle later.
- In RUN with pix_valid=0, wr_req to addr 0x05 with data 0x2A -> wr_ack pulses once, the cycle after the request. A lookup of idx 0x05 then returns 0x2A.
- Hold pix_valid=1 for 10 cycles while wr_req is high (addr 0x0A, data 0x01) -> no wr_ack during those 10 cycles. The write is accepted in the first cycle pix_valid=0; wr_ack follows 1 cycle later and idx 0x0A then reads 0x01.
- Write addr 0x10 with data 0x30 -> lookups of idx 0x00, 0x10, 0x14 and 0x0C all return 0x30 (mirror plus backdrop). idx 0x0D is unchanged at 0x19.
- After the 0x05 write, pulse reload -> init_done=0 the next cycle, and lookups return 0x0F during the copy. After 32 cycles init_done=1 and idx 0x05 returns 0x11 again.
- Assert rst at copy count 17 -> the copy restarts from rom_addr 0 and init_done rises 32 cycles after rst falls.
